// File: rtl/i2s_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx_if
//  Description : Bundles the sample-side inputs and codec-side outputs of the
//                I2S transmitter.
//                  en          transmitter enable (low = held in reset state)
//                  din_l/din_r left/right PCM sample words, DATA_W bits
//                  frame_tick  one-cycle pulse when din_l/din_r are latched
//                  bclk        I2S bit clock
//                  lrclk       word select, 0 = left, 1 = right
//                  sdata       serial data, MSB first
//                master : the sample source (drives en/din, observes pins)
//                slave  : the transmitter itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2s_tx_if #(
  parameter int DATA_W = 16
);
  logic              en;
  logic [DATA_W-1:0] din_l;
  logic [DATA_W-1:0] din_r;
  logic              frame_tick;
  logic              bclk;
  logic              lrclk;
  logic              sdata;

  modport master (
    output en, din_l, din_r,
    input  frame_tick, bclk, lrclk, sdata
  );

  modport slave (
    input  en, din_l, din_r,
    output frame_tick, bclk, lrclk, sdata
  );
endinterface
`default_nettype wire

// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx
//  Description : Serializes 16-bit stereo PCM into an I2S stream for a codec
//                in slave mode. BCLK = clk96M / (2*DIV_HALF); each channel
//                slot is SLOT_BITS BCLKs, so a frame is 2*SLOT_BITS*2*DIV_HALF
//                clk96M cycles (2000 at the defaults -> 48 kHz).
//  Ports       : clk96M  system clock, 96 MHz
//                reset   synchronous, active-high
//                bus     i2s_tx_if.slave (en, din_l, din_r in;
//                        frame_tick, bclk, lrclk, sdata out, all registered)
//  Parameters  : DIV_HALF  clk96M cycles per BCLK half-period
//                SLOT_BITS BCLK periods per channel slot (>= DATA_W+1)
//                DATA_W    sample width
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx #(
  parameter int DIV_HALF  = 25,
  parameter int SLOT_BITS = 20,
  parameter int DATA_W    = 16
) (
  input  logic       clk96M,
  input  logic       reset,
  i2s_tx_if.slave    bus
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;

  logic [DIV_W-1:0]  r_div_cnt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_bclk;
  logic              r_lrclk;
  logic              r_sdata;
  logic              r_frame_tick;
  logic [DATA_W-1:0] r_shadow_l;
  logic [DATA_W-1:0] r_shadow_r;

  logic              w_div_wrap;
  logic              w_fall;
  logic              w_bit_wrap;
  logic [CNT_W-1:0]  w_bit_nxt;
  logic              w_right_nxt;
  logic [CNT_W-1:0]  w_k;
  logic [DATA_W-1:0] w_word;
  logic              w_sdata_nxt;

  // A fall event is the divider wrap while bclk is currently high.
  assign w_div_wrap  = (r_div_cnt == DIV_W'(DIV_HALF - 1));
  assign w_fall      = w_div_wrap && r_bclk;
  assign w_bit_wrap  = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign w_bit_nxt   = w_bit_wrap ? '0 : r_bit_cnt + 1'b1;
  assign w_right_nxt = (w_bit_nxt >= CNT_W'(SLOT_BITS));
  assign w_k         = w_right_nxt ? (w_bit_nxt - CNT_W'(SLOT_BITS)) : w_bit_nxt;
  assign w_word      = w_right_nxt ? r_shadow_r : r_shadow_l;

  // Slot position 0 is the one-BCLK I2S delay and positions beyond DATA_W are
  // padding; both stay 0. At the wrap the new position is 0, so the shadow
  // reload happening in the same cycle never reaches sdata early.
  always_comb begin
    w_sdata_nxt = 1'b0;
    for (int i = 1; i <= DATA_W; i++) begin
      if (w_k == CNT_W'(i)) begin
        w_sdata_nxt = w_word[DATA_W-i];
      end
    end
  end

  always_ff @(posedge clk96M) begin
    if (reset || !bus.en) begin
      r_div_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_bclk       <= 1'b0;
      r_lrclk      <= 1'b0;
      r_sdata      <= 1'b0;
      r_frame_tick <= 1'b0;
      r_shadow_l   <= '0;
      r_shadow_r   <= '0;
    end else begin
      r_frame_tick <= 1'b0;
      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_bclk    <= ~r_bclk;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      // Serial state moves only on falling BCLK so sdata is stable for a
      // full half-period around the codec's rising-edge sample point.
      if (w_fall) begin
        r_bit_cnt <= w_bit_nxt;
        r_lrclk   <= w_right_nxt;
        r_sdata   <= w_sdata_nxt;
        if (w_bit_wrap) begin
          r_shadow_l   <= bus.din_l;
          r_shadow_r   <= bus.din_r;
          r_frame_tick <= 1'b1;
        end
      end
    end
  end

  assign bus.bclk       = r_bclk;
  assign bus.lrclk      = r_lrclk;
  assign bus.sdata      = r_sdata;
  assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire
